// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states, LFSR seed and latched request.
// Imported by the responder top.
package mem_responder_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // index carries the full word address; the top slices off what storage needs
    typedef struct packed {
        logic        op;        // 1 = write, 0 = read
        logic [29:0] index;
        logic        range_ok;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the rv32i multicycle control and the memory responder.
// The initiator holds mem_read/mem_write until it sees mem_resp.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata, mem_err
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Word storage with byte-lane write enables; read data registered on every edge.
// No reset: contents survive rst_n.
module mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem_q[idx];
    end
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder; mem_resp pulses LATENCY cycles after the accepting edge.
// Latency LATENCY (plus 0..3 random stall cycles with MEM_RESPONDER_STALL_EN defined).
// No backpressure: initiator holds its request until mem_resp; inputs ignored while busy.
module mem_responder
    import mem_responder_types::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "mem_responder: LATENCY must be within 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
        $fatal(1, "mem_responder: ADDR_W must be within 1..29");
    end

    mem_resp_state_t state_q;
    logic [4:0]      cnt_q;
    mem_req_t        req_q;
    logic            resp_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    mem_req_t    live_req;
    mem_req_t    cur_req;
    logic        req_vld;
    logic        accept;
    logic        enter_resp;
    logic        arr_we;
    logic [1:0]  extra;
    logic [4:0]  load;
    logic [31:0] arr_rdata;

    always_comb begin
        live_req          = '0;
        live_req.op       = bus.mem_write;
        live_req.index    = bus.mem_address[31:2];
        live_req.range_ok = (bus.mem_address >> (ADDR_W + 2)) == 32'd0;
        live_req.be       = bus.mem_byte_enable;
        live_req.wdata    = bus.mem_wdata;
    end

    // In IDLE the array must see the live request so LATENCY=1 can commit on the accepting edge
    assign cur_req    = (state_q == IDLE) ? live_req : req_q;
    assign req_vld    = bus.mem_read | bus.mem_write;
    assign accept     = (state_q == IDLE) && req_vld;
    assign load       = 5'(LATENCY - 1) + {3'b000, extra};
    assign enter_resp = (accept && load == 5'd0) || (state_q == WAIT && cnt_q == 5'd1);
    assign arr_we     = enter_resp && cur_req.op && cur_req.range_ok;

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
    assign extra = lfsr_q[1:0];
`else
    assign extra = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q   <= live_req;
                        cnt_q   <= load;
                        state_q <= (load == 5'd0) ? RESP : WAIT;
                        if ((bus.mem_read && bus.mem_write) || !live_req.range_ok) err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) state_q <= RESP;
                end
                RESP: begin
                    resp_q  <= 1'b1;
                    state_q <= IDLE;
                    if (!req_q.op) rdata_q <= req_q.range_ok ? arr_rdata : 32'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_array #(.ADDR_W(ADDR_W)) u_mem_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (cur_req.be),
        .idx   (cur_req.index[ADDR_W-1:0]),
        .wdata (cur_req.wdata),
        .rdata (arr_rdata)
    );

    logic unused_bits;
    assign unused_bits = ^{bus.mem_address[1:0], cur_req.index[29:ADDR_W]};

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.mem_err   = err_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the rv32i multicycle datapath/control pair.
- Accepts one word-aligned read or write request at a time (mem_read/mem_write, 4-bit byte enable) and holds it for a fixed latency.
- Commits writes with per-byte enables and returns mem_resp with registered read data.
- Serves as the synthesizable backing memory for bench and FPGA runs, replacing the magic-memory model.

Parameters:
- ADDR_W, 10, word-index width; storage holds 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to mem_resp. Legal range 1..15; any other value fails an elaboration-time $fatal.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_read  input  1  read request; held by the initiator until mem_resp.
- mem_write  input  1  write request; held by the initiator until mem_resp.
- mem_byte_enable  input  4  write lane enables; bit i selects wdata[8i+7:8i].
- mem_address  input  32  byte address; bits [1:0] are ignored.
- mem_wdata  input  32  write data, already lane-shifted by the initiator.
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  32  read word, registered.
- mem_err  output  1  sticky protocol/range error flag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - mem_resp=0, mem_rdata=0, mem_err=0.
  - State IDLE, counter 0.
  - Storage contents are not reset.
- Word index = mem_address[ADDR_W+1:2].
- Out of range: mem_address[31:ADDR_W+2] != 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is high at an edge, latch op, index, range bit, byte enable and wdata.
  - Load cnt=LATENCY-1.
  - Go to WAIT if LATENCY>1, else RESP.
- WAIT:
  - cnt decrements each cycle; at cnt==1 the next state is RESP.
  - Request inputs are ignored while in WAIT (latched copy used), including if the initiator changes them mid-flight.
- Edge entering RESP:
  - Read: mem_rdata <= storage[index], or 0 if out of range.
  - Write: storage lanes with enable=1 are updated; mem_rdata is unchanged.
  - Write with byte_enable=0000: respond, storage unchanged.
  - Out-of-range write: storage unchanged.
- RESP:
  - mem_resp=1 for exactly one cycle, then IDLE.
  - A request still high in the IDLE cycle after RESP is a new transaction.
  - Back-to-back throughput: one transaction per LATENCY+1 cycles.
- Total latency: mem_resp high LATENCY cycles after the accepting edge (LATENCY=2: request sampled at edge 0, mem_resp high between edges 2 and 3).
- Read-after-write to the same word returns the new data.
- mem_rdata holds the last read value between responses.
- mem_err is set at the accepting edge, is never cleared except by reset, and the transaction still completes when:
  - mem_read and mem_write are both high; the request is treated as a write.
  - The address is out of range.
- Reset mid-transaction aborts it: no mem_resp, no write commit (writes only commit entering RESP).

Optional Feature:
- Macro: MEM_RESPONDER_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted request.
  - Its low 2 bits add 0..3 extra WAIT cycles to that transaction.
  - Latency becomes LATENCY..LATENCY+3. This exercises control-FSM stall handling.
- Undefined: no LFSR is present and latency is exactly LATENCY.

Decomposition:
- Package mem_responder_types:
  - enum mem_resp_state_t {IDLE, WAIT, RESP}.
  - localparam LFSR_SEED=16'hACE1.
  - typedef mem_req_t struct (op, index, range_ok, be, wdata) for the latched request.
- Sub-module mem_array:
  - 2**ADDR_W x 32 storage, synchronous read, byte-enabled synchronous write.
  - Ports clk, we, be, idx, wdata, rdata.
- FSM, counter, error flag and LFSR stay in mem_responder.

Test Plan:
- Reset then read idx 5 (storage preloaded 32'hDEADBEEF), LATENCY=2 -> mem_resp high exactly 2 cycles after accept, mem_rdata=32'hDEADBEEF, mem_err=0.
- Write 32'h000000AB, be=0001, addr 0x14 over 0x11223344, then read 0x14 -> mem_rdata=32'h112233AB.
- Write be=1100, wdata 32'hCAFE0000 to 0x18 over 0, then read -> 32'hCAFE0000; write be=0000 -> word unchanged, mem_resp still pulses.
- Read addr 0x0001_0000 with ADDR_W=10 -> mem_rdata=0, mem_err=1 and stays 1 through later good transactions until rst_n low.
- Assert mem_read and mem_write together with wdata 32'h5A5A5A5A, be=1111, addr 0x20 -> treated as write, word=32'h5A5A5A5A, mem_err=1.
- Start write to 0x24 (old 32'h1), drop rst_n during WAIT -> no mem_resp; after reset, read 0x24 -> 32'h1. With MEM_RESPONDER_STALL_EN, 100 reads -> every latency within 2..5 and both bounds observed.
